// File: rtl/shift_word_tx_if.sv
// Upstream word handshake into shift_word_tx: 16-bit data with valid/ready.
interface shift_word_tx_if;
   localparam int unsigned DATA_W = 16;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/shift_word_tx.sv
// Word FIFO feeding an MSB-first dout/shift_clk/latch serializer for a 16-bit
// shift-in receiver; every output comes straight from a flop.
module shift_word_tx #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   shift_word_tx_if.slave                   up,
   output logic                             dout,
   output logic                             shift_clk,
   output logic                             latch,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LATCH,
      S_GAP
   } state_e;

   state_e              state_q;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                in_ready_q;
   logic [DATA_W-1:0]   shreg_q;
   logic [3:0]          bit_cnt_q;
   logic [DIV_W-1:0]    div_q;
   logic                dout_q;
   logic                sclk_q;
   logic                latch_q;
   logic                busy_q;
   logic                push_c;
   logic                pop_c;
   logic                div_done_c;
   logic [DATA_W-1:0]   head_c;

   assign push_c     = up.in_valid & in_ready_q;
   assign pop_c      = (state_q == S_IDLE) && (count_q != '0);
   assign div_done_c = (div_q == DIV_LAST);
   assign head_c     = mem_q[rd_ptr_q];

   // Occupancy after this edge; push and pop together cancel out.
   always_comb begin
      count_d = count_q;
      unique case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q    <= count_d;
         in_ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= up.in_data;
   end

   // Frame sequencer; shreg_q holds the bits still to send, left-aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         dout_q    <= 1'b0;
         sclk_q    <= 1'b0;
         latch_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         div_q  <= div_done_c ? '0 : div_q + DIV_W'(1);
         busy_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               div_q  <= '0;
               busy_q <= pop_c | (count_d != '0);
               if (pop_c) begin
                  shreg_q   <= {head_c[DATA_W-2:0], 1'b0};
                  bit_cnt_q <= 4'd15;
                  dout_q    <= head_c[DATA_W-1];
                  state_q   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (div_done_c) begin
                  sclk_q  <= 1'b1;
                  state_q <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (div_done_c) begin
                  sclk_q <= 1'b0;
                  if (bit_cnt_q == 4'd0) begin
                     dout_q  <= 1'b0;
                     latch_q <= 1'b1;
                     state_q <= S_LATCH;
                  end else begin
                     bit_cnt_q <= bit_cnt_q - 4'd1;
                     dout_q    <= shreg_q[DATA_W-1];
                     shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                     state_q   <= S_SETUP;
                  end
               end
            end
            S_LATCH: begin
               if (div_done_c) begin
                  latch_q <= 1'b0;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (div_done_c) begin
                  state_q <= S_IDLE;
                  busy_q  <= (count_d != '0);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign up.in_ready = in_ready_q;
   assign dout        = dout_q;
   assign shift_clk   = sclk_q;
   assign latch       = latch_q;
   assign busy        = busy_q;
   assign fifo_count  = count_q;
endmodule
